// File: rtl/image_loader.sv
// image_loader: receives a row-major pixel stream into a DATA_X x DATA_Y frame
// buffer, checks frame length against pix_last, then hands the buffer to the
// convolution layer with a one-cycle conv_enable pulse and holds it frozen
// until conv_done.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pix_valid/data/last, pix_ready   upstream pixel stream (ready/valid)
//   rd_row, rd_col, rd_data          combinational buffer read port
//   conv_enable, conv_done           handshake with the convolution layer
//   frame_err                        one-cycle pulse on a mis-framed stream
//   frame_count                      frames handed to conv (wraps at 16 bits)
module image_loader #(
    parameter int unsigned DATA_X    = 28,
    parameter int unsigned DATA_Y    = 28,
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid,
    input  logic [DATA_SIZE-1:0] pix_data,
    input  logic                 pix_last,
    output logic                 pix_ready,
    input  logic [4:0]           rd_row,
    input  logic [4:0]           rd_col,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 conv_enable,
    input  logic                 conv_done,
    output logic                 frame_err,
    output logic [15:0]          frame_count
);

    localparam int unsigned DEPTH  = DATA_X * DATA_Y;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        BUSY = 2'd3
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    idx;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic                 accept;
    logic                 rd_in_range;
    logic [ADDR_W-1:0]    rd_addr;

    // pix_ready is a registered copy of (state == LOAD), so it qualifies writes.
    assign accept = pix_valid && pix_ready;

    // Combinational read; out-of-range coordinates return zero.
    assign rd_in_range = ({1'b0, rd_row} < 6'(DATA_X)) && ({1'b0, rd_col} < 6'(DATA_Y));
    assign rd_addr     = ADDR_W'(rd_row) * ADDR_W'(DATA_Y) + ADDR_W'(rd_col);
    assign rd_data     = rd_in_range ? mem[rd_addr] : '0;

    // Frame buffer: not reset; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[idx] <= pix_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            pix_ready   <= 1'b0;
            conv_enable <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            conv_enable <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= LOAD;
                    pix_ready <= 1'b1;
                end
                LOAD: begin
                    if (accept) begin
                        if ((idx == LAST_IDX) && pix_last) begin
                            idx         <= '0;
                            state       <= ARM;
                            pix_ready   <= 1'b0;
                            conv_enable <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else if ((idx == LAST_IDX) || pix_last) begin
                            // Mis-framed: drop the partial frame and restart.
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (conv_done) begin
                        state     <= LOAD;
                        pix_ready <= 1'b1;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (conv_done) begin
                        state     <= LOAD;
                        pix_ready <= 1'b1;
                        idx       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: stimulus pushes expected conv_enable /
// frame_err events into a queue, a monitor pops them on every output pulse.
module tb_image_loader;

    localparam int unsigned NX    = 28;
    localparam int unsigned NY    = 28;
    localparam int unsigned NPIX  = NX * NY;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_data = '0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic [4:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic [31:0] rd_data;
    logic        conv_enable;
    logic        conv_done = 1'b0;
    logic        frame_err;
    logic [15:0] frame_count;

    image_loader #(.DATA_X(NX), .DATA_Y(NY), .DATA_SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .conv_enable (conv_enable),
        .conv_done   (conv_done),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_arm;
        logic [15:0] fc;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model_mem [NPIX];
    int          pos    = 0;
    logic [15:0] exp_fc = '0;
    bit          hung   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is good only if pix_last lands exactly on beat NPIX.
    function automatic void model_accept(input logic [31:0] d, input bit last);
        ev_t e;
        model_mem[pos] = d;
        if (last || pos == NPIX - 1) begin
            if (last && pos == NPIX - 1) begin
                exp_fc   = exp_fc + 16'd1;
                e.is_arm = 1'b1;
                e.fc     = exp_fc;
            end else begin
                e.is_arm = 1'b0;
                e.fc     = '0;
            end
            exp_q.push_back(e);
            pos = 0;
        end else begin
            pos++;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] d, input bit last);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        while (!pix_ready && !hung && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            if (!hung) begin
                checks++;
                fails++;
                $display("FAIL beat_timeout: pix_ready stayed 0, expected 1 at %0t", $time);
            end
            hung = 1'b1;
        end else begin
            @(posedge clk);
            model_accept(d, last);
        end
        @(negedge clk);
    endtask

    task automatic frame(input int n, input int last_at, input bit rnd, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 9) < 3) begin
                    pix_valid = 1'b0;
                    @(negedge clk);
                end
            end
            send(rnd ? $urandom : 32'(i), (i + 1) == last_at);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic release_conv(input int wait_cycles);
        pix_valid = 1'b0;
        conv_done = 1'b0;
        repeat (wait_cycles) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        chk("pix_ready_after_done", 32'(pix_ready), 32'd1);
    endtask

    task automatic rd(input int r, input int c);
        logic [31:0] e;
        rd_row = 5'(r);
        rd_col = 5'(c);
        #1;
        e = (r < NX && c < NY) ? model_mem[r * NY + c] : 32'd0;
        chk($sformatf("rd_data(%0d,%0d)", r, c), rd_data, e);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    bit          fc_pending = 1'b0;
    logic [15:0] fc_want;
    bit          prev_en = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (fc_pending) begin
            chk("frame_count_after_arm", 32'(frame_count), 32'(fc_want));
            chk("conv_enable_one_cycle", 32'(conv_enable), 32'd0);
            fc_pending = 1'b0;
        end
        if ((conv_enable && !prev_en) || frame_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: conv_enable=%0b frame_err=%0b, expected none at %0t",
                         conv_enable, frame_err, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_conv_enable", 32'(conv_enable), 32'(e.is_arm));
                chk("pulse_kind_frame_err", 32'(frame_err), 32'(!e.is_arm));
                if (conv_enable) begin
                    fc_pending = 1'b1;
                    fc_want    = e.fc;
                end
            end
        end
        prev_en = conv_enable;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and the single IDLE cycle after release.
        @(negedge clk);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_conv_enable", 32'(conv_enable), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_pix_ready", 32'(pix_ready), 32'd0);
        @(negedge clk);
        chk("load_pix_ready", 32'(pix_ready), 32'd1);

        // Clean frame, pixel = index, valid held high.
        frame(NPIX, NPIX, 1'b0, 1'b0);
        chk("arm_conv_enable", 32'(conv_enable), 32'd1);
        chk("arm_pix_ready", 32'(pix_ready), 32'd0);
        // Hold in BUSY with junk offered upstream; buffer must not change.
        pix_valid = 1'b1;
        pix_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 50; k++) begin
            chk("busy_pix_ready", 32'(pix_ready), 32'd0);
            @(negedge clk);
        end
        chk("frame_count_1", 32'(frame_count), 32'd1);
        rd(5, 3);
        rd(0, 0);
        rd(27, 27);
        release_conv(0);
        rd(5, 3);

        // conv_done while loading is ignored; early pix_last -> frame_err.
        conv_done = 1'b1;
        frame(100, 100, 1'b0, 1'b0);
        conv_done = 1'b0;
        // Full-length frame without pix_last -> frame_err.
        frame(NPIX, 0, 1'b1, 1'b0);
        chk("frame_count_after_errs", 32'(frame_count), 32'(exp_fc));
        rd(13, 7);

        // conv_done during ARM: straight back to LOAD.
        frame(NPIX, NPIX, 1'b1, 1'b0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        chk("arm_to_load_pix_ready", 32'(pix_ready), 32'd1);
        chk("frame_count_2", 32'(frame_count), 32'(exp_fc));

        // Reset mid-frame abandons it.
        frame(400, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_pix_ready", 32'(pix_ready), 32'd0);
        chk("midrst_conv_enable", 32'(conv_enable), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        pos    = 0;
        exp_fc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_idle_pix_ready", 32'(pix_ready), 32'd0);
        @(negedge clk);
        frame(NPIX, NPIX, 1'b0, 1'b0);
        release_conv(3);

        // Three frames with random data and idle gaps.
        for (int f = 0; f < 3; f++) begin
            frame(NPIX, NPIX, 1'b1, 1'b1);
            release_conv($urandom_range(0, 5));
        end
        chk("frame_count_final", 32'(frame_count), 32'(exp_fc));
        rd(27, 27);
        rd(28, 3);
        rd(3, 28);
        for (int k = 0; k < 16; k++) begin
            rd($urandom_range(0, 31), $urandom_range(0, 31));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
